pipeline_stage_register: RTL and testbench
==========================================

Name: pipeline_stage_register

Overview:
- Generic, parametrised successor to the fixed-field stage registers between pipeline stages (fetch/decode, decode/execute, execute/memory, memory/writeback).
- Carries a packed datapath bundle and a packed control bundle with a valid/ready handshake, stall back-pressure, flush, and bubble insertion.
- Contains a two-entry skid buffer, so inReady is driven from a flop and does not depend combinationally on outReady.

Parameters:
- DATA_WIDTH, 128: width of the packed datapath bundle (pc, operands, immediate, register indices, func fields).
- CTRL_WIDTH, 16: width of the packed control bundle (enables, mux selects, ALU op).
- CLEAR_DATA_ON_BUBBLE, 0: when 1, outData is zeroed whenever outValid=0; when 0, outData holds its last value.
- COUNTER_WIDTH, 32: width of the performance counters. Used only when the optional feature is enabled.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- flush  in  1  discard all held entries and any same-cycle input transfer.
- inValid  in  1  upstream stage presents a valid bundle.
- inReady  out  1  stage can accept a bundle; registered.
- inData  in  DATA_WIDTH  upstream datapath bundle.
- inCtrl  in  CTRL_WIDTH  upstream control bundle.
- outValid  out  1  downstream bundle is valid.
- outReady  in  1  downstream stage accepts the bundle.
- outData  out  DATA_WIDTH  datapath bundle to the next stage.
- outCtrl  out  CTRL_WIDTH  control bundle to the next stage; zero whenever outValid=0.
- occupancy  out  2  number of held entries (0, 1 or 2).

Behaviour:
- Storage: a main register (drives the outputs) and a skid register, each with its own valid bit.
- Transfer definitions:
  - Accept = inValid & inReady.
  - Drain = outValid & outReady.
- State encoding: occupancy, with EMPTY=0, ONE=1, FULL=2.
- Transitions when flush=0:
  - EMPTY: Accept loads main → ONE.
  - ONE: Accept & Drain → main reloads, stay ONE. Accept & !Drain → load skid, go FULL. !Accept & Drain → EMPTY.
  - FULL: Drain → skid moves into main, skid cleared → ONE. Accept is impossible in FULL because inReady=0.
- inReady: registered; equals 1 in the cycle after any edge that leaves the skid register empty, 0 while FULL.
- Latency: a bundle accepted at edge N appears on outData/outCtrl after edge N with outValid=1, i.e. one cycle. Order is strictly preserved.
- Bubble rule: when outValid=0, outCtrl=0. Stray enables (for example a register or memory write enable) can therefore never reach the next stage.
- flush=1 at an edge:
  - Both valid bits cleared, occupancy=0, inReady=1.
  - Any same-cycle Accept is dropped; any same-cycle Drain still counts as taken by downstream.
  - outCtrl=0 from the next cycle. outData is zeroed only if CLEAR_DATA_ON_BUBBLE=1.
- Stall: holding outReady=0 freezes main; at most one further bundle is absorbed into skid, then inReady deasserts.
- reset=0 at an edge:
  - outValid=0, outData=0, outCtrl=0, occupancy=0, inReady=1, skid cleared.
  - Reset overrides flush and all handshakes. Inputs in reset cycles are ignored.
  - Reset asserted mid-operation discards held entries with no partial output.
- Widths: data and control pass through unmodified; no arithmetic. outData/outCtrl must never change while outValid=1 & outReady=0.

Optional Feature:
- Macro: PIPELINE_STAGE_REGISTER_PERF_COUNTERS_EN.
- When defined, these output ports are added:
  - stallCycles  out  COUNTER_WIDTH  increments each cycle with outValid=1 & outReady=0.
  - flushCount  out  COUNTER_WIDTH  increments each edge where flush=1 and occupancy>0.
  - Both counters saturate at all-ones and reset to 0.
- When not defined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset held low 3 cycles with inValid=1, inData=0xAB, then released → outValid=0, outCtrl=0, occupancy=0, inReady=1; nothing is captured.
- Stream 0x01..0x08 with inValid=1 and outReady=1 every cycle → outData is 0x01..0x08 in order, each one cycle after acceptance; occupancy stays 1.
- Send 0x10, 0x11, 0x12 with outReady=0 → 0x10 held on outData, 0x11 in skid, inReady=0 after the second accept, 0x12 not accepted. Then raise outReady → outputs 0x10, 0x11, 0x12 with no loss or duplication.
- Reach FULL, then pulse flush=1 for one cycle with inValid=1, inData=0x55, inCtrl=0x00FF → next cycle outValid=0, outCtrl=0, occupancy=0, inReady=1; 0x55 never appears.
- Drive inValid=0 for 2 cycles between 0x20 and 0x21 with inCtrl=0xFFFF → outCtrl=0 during the bubble cycles; outData equals 0 only if CLEAR_DATA_ON_BUBBLE=1.
- Macro defined, COUNTER_WIDTH=4, outValid=1 with outReady=0 for 20 cycles → stallCycles saturates at 15; 2 flushes while non-empty → flushCount=2.

Source files
------------

// File: rtl/pipeline_stage_register.sv
// ---------------------------------------------------------------------------
// pipeline_stage_register
//
// Generic stage register placed between pipeline stages. It carries a packed
// datapath bundle and a packed control bundle with a valid/ready handshake,
// flush, and bubble insertion. A two-entry skid buffer (main + skid) keeps
// inReady a pure flop output, so it never depends combinationally on outReady.
//
// Handshake: a bundle moves across an interface on a rising edge where both
// valid and ready are high (Accept = inValid & inReady, Drain = outValid &
// outReady). Once outValid is high, outData/outCtrl stay stable until Drain.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   flush      in   discard all held entries and any same-cycle Accept
//   inValid    in   upstream bundle valid
//   inReady    out  stage can accept a bundle (registered)
//   inData     in   upstream datapath bundle   [DATA_WIDTH]
//   inCtrl     in   upstream control bundle    [CTRL_WIDTH]
//   outValid   out  downstream bundle valid
//   outReady   in   downstream accepts the bundle
//   outData    out  datapath bundle            [DATA_WIDTH]
//   outCtrl    out  control bundle, zero when outValid=0 [CTRL_WIDTH]
//   occupancy  out  held entries (0, 1, 2); this is also the FSM state
//
// Optional build macro PIPELINE_STAGE_REGISTER_PERF_COUNTERS_EN adds:
//   stallCycles out  cycles with outValid=1 & outReady=0 (saturating)
//   flushCount  out  flushes seen while non-empty (saturating)
// ---------------------------------------------------------------------------
module pipeline_stage_register #(
  parameter int unsigned DATA_WIDTH           = 128,
  parameter int unsigned CTRL_WIDTH           = 16,
  parameter bit          CLEAR_DATA_ON_BUBBLE = 1'b0
`ifdef PIPELINE_STAGE_REGISTER_PERF_COUNTERS_EN
  , parameter int unsigned COUNTER_WIDTH      = 32
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic [CTRL_WIDTH-1:0] inCtrl,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [CTRL_WIDTH-1:0] outCtrl,
  output logic [1:0]            occupancy
`ifdef PIPELINE_STAGE_REGISTER_PERF_COUNTERS_EN
  , output logic [COUNTER_WIDTH-1:0] stallCycles
  , output logic [COUNTER_WIDTH-1:0] flushCount
`endif
);

  // The state value is the occupancy: main valid <=> state != EMPTY,
  // skid valid <=> state == FULL.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic                  in_ready_q, in_ready_d;

  logic main_valid;
  logic accept;
  logic drain;

  assign main_valid = (state_q != EMPTY);
  assign accept     = inValid & in_ready_q;
  assign drain      = main_valid & outReady;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Same-cycle Accept is dropped; a same-cycle Drain was already taken.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_d = inData;
            main_ctrl_d = inCtrl;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_data_d = inData;
            main_ctrl_d = inCtrl;
          end else if (accept) begin
            // Downstream stalled: park the new bundle behind main.
            skid_data_d = inData;
            skid_ctrl_d = inCtrl;
            state_d     = FULL;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // inReady is low here, so only a Drain can happen.
          if (drain) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_data_d = '0;
            skid_ctrl_d = '0;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Ready is decided from the next state so it can be a plain flop.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign inReady   = in_ready_q;
  assign outValid  = main_valid;
  assign occupancy = state_q;
  // Control is forced to zero in bubbles so no stray enable leaks downstream.
  assign outCtrl   = main_valid ? main_ctrl_q : '0;
  assign outData   = (CLEAR_DATA_ON_BUBBLE && !main_valid) ? '0 : main_data_q;

`ifdef PIPELINE_STAGE_REGISTER_PERF_COUNTERS_EN
  logic [COUNTER_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [COUNTER_WIDTH-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (main_valid && !outReady && (stall_cycles_q != {COUNTER_WIDTH{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (flush && main_valid && (flush_count_q != {COUNTER_WIDTH{1'b1}})) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stallCycles = stall_cycles_q;
  assign flushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stage_register
//
// Directed vector table with hand-derived post-edge expectations, a hand
// sequence for the performance counters, then randomized traffic. Every cycle
// the DUT is also compared against a queue-based reference model of the stage.
// ---------------------------------------------------------------------------
module tb_pipeline_stage_register;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int W  = DW + CW;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset     = 1'b0;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data   = '0;
  logic [CW-1:0] in_ctrl   = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
`ifdef PIPELINE_STAGE_REGISTER_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
`endif

  pipeline_stage_register #(
    .DATA_WIDTH          (DW),
    .CTRL_WIDTH          (CW),
    .CLEAR_DATA_ON_BUBBLE(1'b0)
`ifdef PIPELINE_STAGE_REGISTER_PERF_COUNTERS_EN
    , .COUNTER_WIDTH     (CNT_W)
`endif
  ) dut (
    .clock    (clk),
    .reset    (reset),
    .flush    (flush),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .inData   (in_data),
    .inCtrl   (in_ctrl),
    .outValid (out_valid),
    .outReady (out_ready),
    .outData  (out_data),
    .outCtrl  (out_ctrl),
    .occupancy(occupancy)
`ifdef PIPELINE_STAGE_REGISTER_PERF_COUNTERS_EN
    , .stallCycles(stall_cycles)
    , .flushCount (flush_count)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  // Held bundles in order, {data, ctrl}; front is what the stage shows.
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] m_last_data = '0;
  bit            m_ready     = 1'b1;
  int            m_stall     = 0;
  int            m_flushes   = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one rising edge, computed from the stage rules with a queue.
  task automatic model_edge(input bit rst_n, input bit fl, input bit iv,
                            input logic [DW-1:0] id, input logic [CW-1:0] ic,
                            input bit ordy);
    int pre;
    logic [W-1:0] head;
    if (!rst_n) begin
      exp_q.delete();
      m_last_data = '0;
      m_ready     = 1'b1;
      m_stall     = 0;
      m_flushes   = 0;
    end else begin
      pre = exp_q.size();
      if (pre > 0 && !ordy && m_stall < CNT_MAX) m_stall++;
      if (fl && pre > 0 && m_flushes < CNT_MAX) m_flushes++;
      if (fl) begin
        exp_q.delete();
      end else begin
        if (pre > 0 && ordy) head = exp_q.pop_front();
        if (iv && m_ready) exp_q.push_back({id, ic});
      end
      m_ready = (exp_q.size() < 2);
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        m_last_data = head[W-1:CW];
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] head;
    bit           v;
    v = (exp_q.size() > 0);
    head = v ? exp_q[0] : '0;
    check({tag, ".outValid"},  32'(out_valid), 32'(v));
    check({tag, ".outData"},   32'(out_data),  32'(m_last_data));
    check({tag, ".outCtrl"},   32'(out_ctrl),  v ? 32'(head[CW-1:0]) : 32'd0);
    check({tag, ".occupancy"}, 32'(occupancy), 32'(exp_q.size()));
    check({tag, ".inReady"},   32'(in_ready),  32'(m_ready));
`ifdef PIPELINE_STAGE_REGISTER_PERF_COUNTERS_EN
    check({tag, ".stallCycles"}, 32'(stall_cycles), 32'(m_stall));
    check({tag, ".flushCount"},  32'(flush_count),  32'(m_flushes));
`endif
  endtask

  // ---------------- driver ----------------
  // Inputs change at the falling edge; outputs are sampled at the next
  // falling edge, after the rising edge has been applied to the model.
  task automatic step(input bit rst_n, input bit fl, input bit iv,
                      input logic [DW-1:0] id, input logic [CW-1:0] ic,
                      input bit ordy, input string tag);
    reset     = rst_n;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    in_ctrl   = ic;
    out_ready = ordy;
    @(posedge clk);
    model_edge(rst_n, fl, iv, id, ic, ordy);
    @(negedge clk);
    check_model(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            rst_n;
    bit            fl;
    bit            iv;
    logic [DW-1:0] id;
    logic [CW-1:0] ic;
    bit            ordy;
    bit            ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic [1:0]    eocc;
    bit            erdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst_n, input bit fl, input bit iv,
                     input logic [DW-1:0] id, input logic [CW-1:0] ic, input bit ordy,
                     input bit ev, input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                     input logic [1:0] eocc, input bit erdy);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.id = id; v.ic = ic; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eocc = eocc; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  initial begin
    @(negedge clk);

    // Reset held 3 cycles with a valid input present: nothing captured.
    for (int i = 0; i < 3; i++) add(0, 0, 1, 16'h00AB, 16'h1234, 1,  0, 16'h0, 16'h0, 2'd0, 1);
    add(1, 0, 0, 16'h0, 16'h0, 1,  0, 16'h0, 16'h0, 2'd0, 1);
    // Streaming at full rate: one-cycle latency, occupancy 1.
    for (int i = 1; i <= 8; i++)
      add(1, 0, 1, 16'(i), 16'(i) | 16'h0100, 1,  1, 16'(i), 16'(i) | 16'h0100, 2'd1, 1);
    add(1, 0, 0, 16'h0, 16'h0, 1,  0, 16'h08, 16'h0, 2'd0, 1);
    // Stall: 0x10 held, 0x11 into skid, 0x12 refused, then drained in order.
    add(1, 0, 1, 16'h10, 16'h0110, 0,  1, 16'h10, 16'h0110, 2'd1, 1);
    add(1, 0, 1, 16'h11, 16'h0111, 0,  1, 16'h10, 16'h0110, 2'd2, 0);
    add(1, 0, 1, 16'h12, 16'h0112, 0,  1, 16'h10, 16'h0110, 2'd2, 0);
    add(1, 0, 1, 16'h12, 16'h0112, 1,  1, 16'h11, 16'h0111, 2'd1, 1);
    add(1, 0, 1, 16'h12, 16'h0112, 1,  1, 16'h12, 16'h0112, 2'd1, 1);
    add(1, 0, 0, 16'h0,  16'h0,    1,  0, 16'h12, 16'h0,    2'd0, 1);
    // Flush while FULL with a valid input present.
    add(1, 0, 1, 16'h30, 16'h0130, 0,  1, 16'h30, 16'h0130, 2'd1, 1);
    add(1, 0, 1, 16'h31, 16'h0131, 0,  1, 16'h30, 16'h0130, 2'd2, 0);
    add(1, 1, 1, 16'h55, 16'h00FF, 0,  0, 16'h30, 16'h0,    2'd0, 1);
    add(1, 0, 0, 16'h0,  16'h0,    1,  0, 16'h30, 16'h0,    2'd0, 1);
    // Flush in ONE with inReady=1: the same-cycle accept of 0x55 is dropped.
    add(1, 0, 1, 16'h40, 16'h0140, 1,  1, 16'h40, 16'h0140, 2'd1, 1);
    add(1, 1, 1, 16'h55, 16'h00FF, 1,  0, 16'h40, 16'h0,    2'd0, 1);
    add(1, 0, 0, 16'h0,  16'h0,    1,  0, 16'h40, 16'h0,    2'd0, 1);
    // Bubble: control zeroed, data held.
    add(1, 0, 1, 16'h20, 16'hFFFF, 1,  1, 16'h20, 16'hFFFF, 2'd1, 1);
    add(1, 0, 0, 16'h99, 16'hFFFF, 1,  0, 16'h20, 16'h0,    2'd0, 1);
    add(1, 0, 0, 16'h99, 16'hFFFF, 1,  0, 16'h20, 16'h0,    2'd0, 1);
    add(1, 0, 1, 16'h21, 16'hFFFF, 1,  1, 16'h21, 16'hFFFF, 2'd1, 1);
    add(1, 0, 0, 16'h0,  16'h0,    1,  0, 16'h21, 16'h0,    2'd0, 1);
    // Reset mid-operation while FULL.
    add(1, 0, 1, 16'h60, 16'h0160, 0,  1, 16'h60, 16'h0160, 2'd1, 1);
    add(1, 0, 1, 16'h61, 16'h0161, 0,  1, 16'h60, 16'h0160, 2'd2, 0);
    add(0, 1, 1, 16'h62, 16'h0162, 1,  0, 16'h0,  16'h0,    2'd0, 1);
    add(1, 0, 0, 16'h0,  16'h0,    1,  0, 16'h0,  16'h0,    2'd0, 1);

    foreach (vecs[k]) begin
      step(vecs[k].rst_n, vecs[k].fl, vecs[k].iv, vecs[k].id, vecs[k].ic, vecs[k].ordy,
           $sformatf("model[%0d]", k));
      check($sformatf("vec[%0d].outValid", k),  32'(out_valid), 32'(vecs[k].ev));
      check($sformatf("vec[%0d].outData", k),   32'(out_data),  32'(vecs[k].ed));
      check($sformatf("vec[%0d].outCtrl", k),   32'(out_ctrl),  32'(vecs[k].ec));
      check($sformatf("vec[%0d].occupancy", k), 32'(occupancy), 32'(vecs[k].eocc));
      check($sformatf("vec[%0d].inReady", k),   32'(in_ready),  32'(vecs[k].erdy));
    end

    // Counter sequence: 20 stalled cycles, then two flushes while non-empty
    // and one while empty.
    step(0, 0, 0, 16'h0, 16'h0, 0, "cnt_rst");
    step(1, 0, 1, 16'h70, 16'h0170, 0, "cnt_load");
    for (int i = 0; i < 20; i++) step(1, 0, 0, 16'h0, 16'h0, 0, "cnt_stall");
    check("stall_hold.outData", 32'(out_data), 32'h70);
`ifdef PIPELINE_STAGE_REGISTER_PERF_COUNTERS_EN
    check("stallCycles_sat", 32'(stall_cycles), 32'd15);
`endif
    step(1, 1, 0, 16'h0, 16'h0, 0, "cnt_flush1");
    step(1, 0, 1, 16'h71, 16'h0171, 1, "cnt_load2");
    step(1, 1, 0, 16'h0, 16'h0, 1, "cnt_flush2");
    step(1, 1, 0, 16'h0, 16'h0, 1, "cnt_flush_empty");
`ifdef PIPELINE_STAGE_REGISTER_PERF_COUNTERS_EN
    check("flushCount_two", 32'(flush_count), 32'd2);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) != 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 9) < 7,
           16'($urandom),
           16'($urandom),
           $urandom_range(0, 9) < 6,
           "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
